axis_byte_packer: RTL and testbench
===================================

// Module: axis_byte_packer
// PURPOSE
//  Upstream stage of the DES datapath. Packs the 8-bit AXI-Stream byte stream
//  from the UART receiver into 64-bit words. Those words are the plaintext
//  blocks for the DES control FSM.
//  Has a one-word output register, so the next block can fill while a word waits.
//  An inter-byte timeout discards partial blocks, so a dropped byte cannot
//  misalign every following block.
// PARAMETERS
//  TIMEOUT_CYC  1_000_000  idle cycles (10 ms @100 MHz) before a partial word is dropped; 0 = disabled
//  MSB_FIRST    1          1: first byte received -> tdata[63:56]; 0: first byte -> tdata[7:0]
// PORTS
//  clk            in   1   system clock (100 MHz)
//  rst            in   1   reset
//  s_axis_tdata   in   8   byte from UART RX
//  s_axis_tvalid  in   1   byte valid
//  s_axis_tready  out  1   packer can accept a byte
//  m_axis_tdata   out  64  packed 64-bit block
//  m_axis_tvalid  out  1   block valid
//  m_axis_tready  in   1   downstream accepts block
//  timeout_drop   out  1   one-cycle pulse when a partial word is discarded
//  drop_count     out  8   number of timeout drops, saturates at 255
//  byte_cnt       out  4   bytes currently held in the accumulator (0..8)
// BEHAVIOUR
//  Clock and reset: clock clk. Reset rst is synchronous, active-high.
//  Reset values: all state cleared. acc=0, cnt=0, timer=0, out_data=0,
//    m_axis_tvalid=0, timeout_drop=0, drop_count=0.
//  Internal state: acc[63:0], cnt 0..8, out_data[63:0], out_valid, timer.
//  s_axis_tready = (cnt != 8). It is combinational from registered state only.
//  Byte accept (s_axis_tvalid & s_axis_tready):
//    MSB_FIRST=1: acc <= {acc[55:0], byte}. MSB_FIRST=0: acc <= {byte, acc[63:8]}.
//    cnt <= cnt + 1.
//  Move: if cnt==8 and (!out_valid or m_axis_tready), then out_data <= acc,
//    out_valid <= 1, acc <= 0, cnt <= 0.
//    Accept and move never coincide, because tready=0 while cnt==8.
//  Latency: 8th byte accepted in cycle N -> cnt=8 at N+1 -> m_axis_tvalid=1 at N+2.
//  Output handshake:
//    m_axis_tvalid = out_valid; m_axis_tdata = out_data.
//    On m_axis_tvalid & m_axis_tready, out_valid clears, unless a move happens in
//    the same cycle; then it stays 1 with the new word.
//    m_axis_tdata is held stable while tvalid=1 and tready=0.
//  Backpressure: with the output register full and not drained, cnt sits at 8 and
//    s_axis_tready=0. No byte is lost or overwritten.
//  Timeout (TIMEOUT_CYC>0):
//    timer counts cycles while 0<cnt<8 and no byte is accepted.
//    timer clears on any accept, and whenever cnt is 0 or 8.
//    When timer == TIMEOUT_CYC-1 and no accept that cycle: acc<=0, cnt<=0,
//      timer<=0, timeout_drop=1 for the next cycle, drop_count += 1 (saturating).
//    An accept in the same cycle as expiry wins: the byte is taken, timer clears,
//      no drop.
//    Timeout never touches the output register.
//  TIMEOUT_CYC=0: timer is inactive and partial words are kept indefinitely.
//  Reset mid-word or mid-handshake: partial word and pending output are discarded.
//    m_axis_tvalid is 0 in the cycle after rst.
// TESTING
//  1. MSB_FIRST=1, bytes 01 23 45 67 89 AB CD EF back-to-back, tready=1
//     -> one word 0x0123456789ABCDEF, tvalid 2 cycles after the 8th accept.
//  2. MSB_FIRST=0, same bytes -> 0xEFCDAB8967452301.
//  3. tready=0, send 16 bytes
//     -> word 1 held stable; s_axis_tready drops after byte 16.
//     Raise tready -> word 1, then word 2, in order, nothing lost.
//  4. TIMEOUT_CYC=100: send 3 bytes, idle 100 cycles
//     -> timeout_drop pulses once, drop_count=1, byte_cnt=0.
//     Then 8 bytes -> one clean word.
//  5. Byte arrives exactly in the expiry cycle -> no drop; byte_cnt increments.
//  6. rst asserted after 5 bytes and with a word pending
//     -> m_axis_tvalid=0, byte_cnt=0, drop_count=0 the next cycle.

Source files
------------

// File: rtl/axis_byte_packer_if.sv
// AXI-Stream style handshake bundle (data/valid/ready) used on both sides of
// the byte packer; W selects the data width of each instance.
interface axis_byte_packer_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into 64-bit words behind a one-word
// output register; an inter-byte timeout discards stale partial words.
module axis_byte_packer #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    axis_byte_packer_if.slave   s_axis,
    axis_byte_packer_if.master  m_axis,
    output logic                timeout_drop,
    output logic [7:0]          drop_count,
    output logic [3:0]          byte_cnt
);

    localparam int             TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    logic [63:0]   acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_drop_q, timeout_drop_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic accept;
    logic move;

    // Ready depends only on registered state, so upstream sees no comb path back.
    assign s_axis.tready = (cnt_q != 4'd8);
    assign accept        = s_axis.tvalid && (cnt_q != 4'd8);
    assign move          = (cnt_q == 4'd8) && (!out_valid_q || m_axis.tready);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        timer_d        = timer_q;
        timeout_drop_d = 1'b0;
        drop_count_d   = drop_count_q;

        if (out_valid_q && m_axis.tready) begin
            out_valid_d = 1'b0;
        end

        // Move and accept are mutually exclusive: accept needs cnt != 8, move needs cnt == 8.
        if (move) begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = 4'd0;
        end else if (accept) begin
            if (MSB_FIRST) begin
                acc_d = {acc_q[55:0], s_axis.tdata};
            end else begin
                acc_d = {s_axis.tdata, acc_q[63:8]};
            end
            cnt_d = cnt_q + 4'd1;
        end

        // Idle timer only runs on a genuinely partial word; an accept always wins over expiry.
        if ((TIMEOUT_CYC != 0) && !accept && (cnt_q != 4'd0) && (cnt_q != 4'd8)) begin
            if (timer_q == TIMER_LAST) begin
                acc_d          = '0;
                cnt_d          = 4'd0;
                timer_d        = '0;
                timeout_drop_d = 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_d = drop_count_q + 8'd1;
                end
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the 64-bit data registers are reset too; a reset must not leave a
            // stale block visible on m_axis_tdata or half-merged into the next word.
            acc_q          <= '0;
            cnt_q          <= 4'd0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            timer_q        <= '0;
            timeout_drop_q <= 1'b0;
            drop_count_q   <= 8'd0;
        end else begin
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            timer_q        <= timer_d;
            timeout_drop_q <= timeout_drop_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign timeout_drop  = timeout_drop_q;
    assign drop_count    = drop_count_q;
    assign byte_cnt      = cnt_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench: two packers (MSB-first and LSB-first) driven in lockstep,
// expected words built from the accepted byte stream and compared on output.
module tb_axis_byte_packer;

    localparam int TO = 100;

    logic clk;
    logic rst;
    logic m_tready;

    axis_byte_packer_if #(.W(8))  s_a ();
    axis_byte_packer_if #(.W(8))  s_b ();
    axis_byte_packer_if #(.W(64)) m_a ();
    axis_byte_packer_if #(.W(64)) m_b ();

    logic       drop_a, drop_b;
    logic [7:0] dcnt_a, dcnt_b;
    logic [3:0] bcnt_a, bcnt_b;

    assign m_a.tready = m_tready;
    assign m_b.tready = m_tready;

    axis_byte_packer #(.TIMEOUT_CYC(TO), .MSB_FIRST(1'b1)) dut_msb (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_a),
        .m_axis       (m_a),
        .timeout_drop (drop_a),
        .drop_count   (dcnt_a),
        .byte_cnt     (bcnt_a)
    );

    axis_byte_packer #(.TIMEOUT_CYC(TO), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_b),
        .m_axis       (m_b),
        .timeout_drop (drop_b),
        .drop_count   (dcnt_b),
        .byte_cnt     (bcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: bytes seen accepted build the expected word for each byte order.
    logic [7:0]  mdl_bytes [8];
    int          mdl_cnt = 0;
    logic [63:0] exp_msb [$];
    logic [63:0] exp_lsb [$];

    always @(negedge clk) begin
        logic [63:0] wm, wl;
        if (!rst) begin
            if (s_a.tvalid && s_a.tready) begin
                check("s_tready_lockstep", 64'(s_b.tready), 64'd1);
                mdl_bytes[mdl_cnt] = s_a.tdata;
                mdl_cnt++;
                if (mdl_cnt == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        wm[63 - 8*i -: 8] = mdl_bytes[i];
                        wl[8*i +: 8]      = mdl_bytes[i];
                    end
                    exp_msb.push_back(wm);
                    exp_lsb.push_back(wl);
                    mdl_cnt = 0;
                end
            end
            if (m_a.tvalid && m_tready) begin
                check("word_expected", 64'(exp_msb.size() != 0), 64'd1);
                check("m_tvalid_lockstep", 64'(m_b.tvalid), 64'd1);
                if (exp_msb.size() != 0) begin
                    check("word_msb", m_a.tdata, exp_msb.pop_front());
                    check("word_lsb", m_b.tdata, exp_lsb.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic took;
        int   n;
        s_a.tdata  = b;
        s_b.tdata  = b;
        s_a.tvalid = 1'b1;
        s_b.tvalid = 1'b1;
        took = 1'b0;
        n    = 0;
        while (!took && n < 200) begin
            @(negedge clk);
            took = s_a.tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_a.tvalid = 1'b0;
        s_b.tvalid = 1'b0;
        if (!took) check("send_stall", 64'(took), 64'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_msb.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        check("drain_done", 64'(exp_msb.size()), 64'd0);
    endtask

    logic [7:0] pat [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        m_tready   = 1'b0;
        s_a.tdata  = '0;
        s_b.tdata  = '0;
        s_a.tvalid = 1'b0;
        s_b.tvalid = 1'b0;
        step(3);
        check("rst_tvalid", 64'(m_a.tvalid), 64'd0);
        check("rst_tdata", m_a.tdata, 64'd0);
        check("rst_byte_cnt", 64'(bcnt_a), 64'd0);
        check("rst_drop_count", 64'(dcnt_a), 64'd0);
        check("rst_timeout_drop", 64'(drop_a), 64'd0);
        check("rst_s_tready", 64'(s_a.tready), 64'd1);
        rst = 1'b0;

        // Back-to-back word, both byte orders, exact output latency.
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(pat[i]);
        check("lat_cnt8", 64'(bcnt_a), 64'd8);
        check("lat_tvalid_early", 64'(m_a.tvalid), 64'd0);
        check("lat_s_tready_full", 64'(s_a.tready), 64'd0);
        step(1);
        check("lat_tvalid", 64'(m_a.tvalid), 64'd1);
        check("word1_msb_const", m_a.tdata, 64'h0123456789ABCDEF);
        check("word1_lsb_const", m_b.tdata, 64'hEFCDAB8967452301);
        check("lat_cnt0", 64'(bcnt_a), 64'd0);
        step(1);
        check("drained_tvalid", 64'(m_a.tvalid), 64'd0);

        // Backpressure: 16 bytes with downstream stalled.
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + 8'(i * 7)));
        check("bp_s_tready", 64'(s_a.tready), 64'd0);
        check("bp_byte_cnt", 64'(bcnt_a), 64'd8);
        check("bp_queued", 64'(exp_msb.size()), 64'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_tvalid_hold", 64'(m_a.tvalid), 64'd1);
            check("bp_tdata_hold_msb", m_a.tdata, exp_msb[0]);
            check("bp_tdata_hold_lsb", m_b.tdata, exp_lsb[0]);
            check("bp_s_tready_hold", 64'(s_a.tready), 64'd0);
            step(1);
        end
        m_tready = 1'b1;
        drain();
        step(2);
        check("bp_tvalid_after", 64'(m_a.tvalid), 64'd0);
        check("bp_cnt_after", 64'(bcnt_a), 64'd0);

        // Timeout: 3 bytes then idle; drop pulse exactly TO cycles after last accept.
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
        check("to_cnt3", 64'(bcnt_a), 64'd3);
        for (int k = 1; k <= TO + 1; k++) begin
            step(1);
            check("to_drop_pulse", 64'(drop_a), 64'(k == TO));
            check("to_drop_pulse_lsb", 64'(drop_b), 64'(k == TO));
            if (k == TO - 1) check("to_cnt_before", 64'(bcnt_a), 64'd3);
            if (k == TO) begin
                check("to_cnt_after", 64'(bcnt_a), 64'd0);
                check("to_drop_count", 64'(dcnt_a), 64'd1);
                mdl_cnt = 0;
            end
        end
        for (int i = 0; i < 8; i++) send_byte(pat[7 - i]);
        drain();
        check("to_clean_drop_count", 64'(dcnt_a), 64'd1);

        // Byte arriving in the expiry cycle is accepted and prevents the drop.
        for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i));
        step(TO - 1);
        check("exp_cnt_pre", 64'(bcnt_a), 64'd3);
        send_byte(8'h5A);
        check("exp_no_drop", 64'(drop_a), 64'd0);
        check("exp_cnt_inc", 64'(bcnt_a), 64'd4);
        step(1);
        check("exp_no_drop_late", 64'(drop_a), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i));
        drain();
        check("exp_drop_count", 64'(dcnt_a), 64'd1);

        // Reset with a word pending and a partial word in the accumulator.
        m_tready = 1'b0;
        for (int i = 0; i < 13; i++) send_byte(8'hC0 + 8'(i));
        check("rs_pending", 64'(m_a.tvalid), 64'd1);
        check("rs_cnt5", 64'(bcnt_a), 64'd5);
        rst = 1'b1;
        step(1);
        check("rs_tvalid", 64'(m_a.tvalid), 64'd0);
        check("rs_byte_cnt", 64'(bcnt_a), 64'd0);
        check("rs_drop_count", 64'(dcnt_a), 64'd0);
        rst = 1'b0;
        exp_msb.delete();
        exp_lsb.delete();
        mdl_cnt  = 0;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(pat[i] ^ 8'h5A);
        drain();
        step(2);
        check("end_tvalid", 64'(m_a.tvalid), 64'd0);
        check("end_queue_lsb", 64'(exp_lsb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
